// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage.
// Produces the registered fetch address, the squash (nop) strobe for the PC
// pipeline and the fetch-valid qualifier. It arbitrates redirects, halts and
// load-use stalls, and owns the post-redirect flush bubble count.
// Optional build macro: PC_MISALIGN_TRAP_EN -- a misaligned redirect target
// loads TRAP_PC and sets a sticky misalign_err flag instead of masking the
// low address bits.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] TRAP_PC      = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        stall_req,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic        nop,
  output logic        fetch_valid,
  output logic        halted,
  output logic        misalign_err
);

  typedef enum logic [1:0] {StRun, StFlush, StHalt} state_e;

  // Counter preload; with a single flush cycle the redirect edge itself is the
  // whole bubble, so the sequencer never leaves RUN.
  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);
  localparam state_e RedirState = (FLUSH_CYCLES == 1) ? StRun : StFlush;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        nop_q, nop_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic        misalign_q, misalign_d;

  logic [31:0] redir_target;
  logic        redir_take;
  logic [31:0] pc_seq;

  assign pc_seq = pc_q + 32'd4;
  // Redirects are honoured in RUN and FLUSH, never in HALT or when frozen.
  assign redir_take = en & redirect & (state_q != StHalt);

`ifdef PC_MISALIGN_TRAP_EN
  logic redir_misaligned;
  assign redir_misaligned = |redirect_pc[1:0];

  // Misaligned targets divert to the trap vector.
  always_comb begin
    redir_target = redir_misaligned ? TRAP_PC : redirect_pc;
  end

  // Sticky error flag, cleared only by reset.
  always_comb begin
    misalign_d = misalign_q | (redir_take & redir_misaligned);
  end
`else
  logic unused_redir_low;
  assign unused_redir_low = ^{redirect_pc[1:0], TRAP_PC};

  // Without the trap, the low two bits are simply dropped.
  always_comb begin
    redir_target = {redirect_pc[31:2], 2'b00};
  end

  // Flag is permanently clear in this build.
  always_comb begin
    misalign_d = 1'b0;
  end
`endif

  // Next-state and next-output selection; everything holds when en is low.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    nop_d         = nop_q;
    fetch_valid_d = fetch_valid_q;
    flush_cnt_d   = flush_cnt_q;

    if (en) begin
      unique case (state_q)
        StRun: begin
          if (redirect) begin
            pc_d          = redir_target;
            nop_d         = 1'b1;
            fetch_valid_d = 1'b1;
            flush_cnt_d   = FlushLoad;
            state_d       = RedirState;
          end else if (halt_req) begin
            nop_d         = 1'b1;
            fetch_valid_d = 1'b0;
            state_d       = StHalt;
          end else if (stall_req) begin
            nop_d         = 1'b0;
            fetch_valid_d = 1'b1;
          end else begin
            pc_d          = pc_seq;
            nop_d         = 1'b0;
            fetch_valid_d = 1'b1;
          end
        end
        StFlush: begin
          if (redirect) begin
            pc_d          = redir_target;
            nop_d         = 1'b1;
            fetch_valid_d = 1'b1;
            flush_cnt_d   = FlushLoad;
            state_d       = RedirState;
          end else begin
            pc_d          = pc_seq;
            fetch_valid_d = 1'b1;
            if (flush_cnt_q == 3'd0) begin
              nop_d   = 1'b0;
              state_d = StRun;
            end else begin
              nop_d       = 1'b1;
              flush_cnt_d = flush_cnt_q - 3'd1;
            end
          end
        end
        StHalt: begin
          if (resume) begin
            pc_d          = pc_seq;
            nop_d         = 1'b0;
            fetch_valid_d = 1'b1;
            state_d       = StRun;
          end else begin
            nop_d         = 1'b1;
            fetch_valid_d = 1'b0;
          end
        end
        default: begin
          state_d = StRun;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StRun;
      pc_q          <= RESET_PC;
      nop_q         <= 1'b0;
      fetch_valid_q <= 1'b0;
      flush_cnt_q   <= 3'd0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      nop_q         <= nop_d;
      fetch_valid_q <= fetch_valid_d;
      flush_cnt_q   <= flush_cnt_d;
      misalign_q    <= en ? misalign_d : misalign_q;
    end
  end

  assign pc           = pc_q;
  assign nop          = nop_q;
  assign fetch_valid  = fetch_valid_q;
  assign halted       = (state_q == StHalt);
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the stimulus process pushes the expected
// post-edge outputs for every cycle, the monitor pops and compares them on the
// following falling edge. Default parameters (FLUSH_CYCLES = 2).
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        stall_req;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc;
  logic        nop;
  logic        fetch_valid;
  logic        halted;
  logic        misalign_err;

  pc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .stall_req   (stall_req),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_req    (halt_req),
    .resume      (resume),
    .pc          (pc),
    .nop         (nop),
    .fetch_valid (fetch_valid),
    .halted      (halted),
    .misalign_err(misalign_err)
  );

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [31:0] MisPc  = 32'h0000_0010;
  localparam logic        MisErr = 1'b1;
`else
  localparam logic [31:0] MisPc  = 32'h0000_0100;
  localparam logic        MisErr = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic        nop;
    logic        fv;
    logic        halted;
    logic        merr;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus the outputs expected right after its edge.
  task automatic step(input logic r, input logic e, input logic st, input logic rd,
                      input logic [31:0] rpc, input logic h, input logic rs,
                      input logic [31:0] epc, input logic enop, input logic efv,
                      input logic eh, input logic em, input string name);
    exp_t x;
    #1;
    rst_n       = r;
    en          = e;
    stall_req   = st;
    redirect    = rd;
    redirect_pc = rpc;
    halt_req    = h;
    resume      = rs;
    @(posedge clk);
    x.pc = epc; x.nop = enop; x.fv = efv; x.halted = eh; x.merr = em; x.name = name;
    exp_q.push_back(x);
  endtask

  // Monitor: compare every presented cycle against the scoreboard head.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        total++;
        if (pc !== x.pc || nop !== x.nop || fetch_valid !== x.fv ||
            halted !== x.halted || misalign_err !== x.merr) begin
          bad++;
          $display("FAIL %s: got pc=%h nop=%b fv=%b halted=%b merr=%b, want pc=%h nop=%b fv=%b halted=%b merr=%b",
                   x.name, pc, nop, fetch_valid, halted, misalign_err,
                   x.pc, x.nop, x.fv, x.halted, x.merr);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; stall_req = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; halt_req = 1'b0; resume = 1'b0;

    //   rst en st rd rpc            h  rs  pc             nop fv h  merr
    step(0, 0, 0, 0, 32'h0,         0, 0,  32'h0,          0, 0, 0, 0, "reset_en0");
    step(0, 1, 0, 0, 32'h0,         0, 0,  32'h0,          0, 0, 0, 0, "reset_en1");
    step(1, 1, 0, 0, 32'h0,         0, 0,  32'h4,          0, 1, 0, 0, "seq_4");
    step(1, 1, 0, 0, 32'h0,         0, 0,  32'h8,          0, 1, 0, 0, "seq_8");
    step(1, 0, 0, 1, 32'h300,       1, 0,  32'h8,          0, 1, 0, 0, "en0_hold");
    // Redirect beats a simultaneous stall.
    step(1, 1, 1, 1, 32'h100,       0, 0,  32'h100,        1, 1, 0, 0, "redir_100");
    step(1, 1, 0, 0, 32'h0,         0, 0,  32'h104,        1, 1, 0, 0, "flush_104");
    step(1, 1, 0, 0, 32'h0,         0, 0,  32'h108,        0, 1, 0, 0, "flush_exit");
    step(1, 1, 0, 0, 32'h0,         0, 0,  32'h10C,        0, 1, 0, 0, "seq_10c");
    // Halt and stall are ignored during FLUSH; a second redirect restarts it.
    step(1, 1, 0, 1, 32'h300,       0, 0,  32'h300,        1, 1, 0, 0, "redir_300");
    step(1, 1, 1, 1, 32'h200,       1, 0,  32'h200,        1, 1, 0, 0, "redir_200_in_flush");
    step(1, 1, 1, 0, 32'h0,         1, 0,  32'h204,        1, 1, 0, 0, "flush_ign_halt");
    step(1, 1, 0, 0, 32'h0,         0, 0,  32'h208,        0, 1, 0, 0, "flush2_exit");
    step(1, 1, 0, 0, 32'h0,         0, 0,  32'h20C,        0, 1, 0, 0, "seq_20c");
    // Walk to pc=20 and stall there for three cycles.
    step(1, 1, 0, 1, 32'h18,        0, 0,  32'h18,         1, 1, 0, 0, "redir_18");
    step(1, 1, 0, 0, 32'h0,         0, 0,  32'h1C,         1, 1, 0, 0, "flush_1c");
    step(1, 1, 0, 0, 32'h0,         0, 0,  32'h20,         0, 1, 0, 0, "flush_20");
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 32'h0,       0, 0,  32'h20,         0, 1, 0, 0, "stall_20");
    end
    step(1, 1, 0, 0, 32'h0,         0, 0,  32'h24,         0, 1, 0, 0, "after_stall");
    // Walk to pc=40 and halt there.
    step(1, 1, 0, 1, 32'h34,        0, 0,  32'h34,         1, 1, 0, 0, "redir_34");
    step(1, 1, 0, 0, 32'h0,         0, 0,  32'h38,         1, 1, 0, 0, "flush_38");
    step(1, 1, 0, 0, 32'h0,         0, 0,  32'h3C,         0, 1, 0, 0, "flush_3c");
    step(1, 1, 0, 0, 32'h0,         0, 0,  32'h40,         0, 1, 0, 0, "seq_40");
    step(1, 1, 1, 0, 32'h0,         1, 0,  32'h40,         1, 0, 1, 0, "halt_40");
    step(1, 1, 0, 1, 32'h500,       0, 0,  32'h40,         1, 0, 1, 0, "halt_ign_redir");
    step(1, 0, 0, 0, 32'h0,         0, 1,  32'h40,         1, 0, 1, 0, "halt_en0_resume");
    step(1, 1, 0, 0, 32'h0,         0, 1,  32'h44,         0, 1, 0, 0, "resume_44");
    step(1, 1, 0, 0, 32'h0,         1, 0,  32'h44,         1, 0, 1, 0, "halt_44");
    step(0, 1, 0, 0, 32'h0,         0, 1,  32'h0,          0, 0, 0, 0, "reset_in_halt");
    step(1, 1, 0, 0, 32'h0,         0, 0,  32'h4,          0, 1, 0, 0, "seq_after_rst");
    // 32-bit wrap during a flush.
    step(1, 1, 0, 1, 32'hFFFF_FFF8, 0, 0,  32'hFFFF_FFF8,  1, 1, 0, 0, "redir_fff8");
    step(1, 1, 0, 0, 32'h0,         0, 0,  32'hFFFF_FFFC,  1, 1, 0, 0, "flush_fffc");
    step(1, 1, 0, 0, 32'h0,         0, 0,  32'h0,          0, 1, 0, 0, "wrap_0");
    // Misaligned target: trap or masked depending on the build.
    step(1, 1, 0, 1, 32'h103,       0, 0,  MisPc,          1, 1, 0, MisErr, "redir_103");
    step(1, 1, 0, 0, 32'h0,         0, 0,  MisPc + 32'd4,  1, 1, 0, MisErr, "mis_flush");
    step(1, 1, 0, 0, 32'h0,         0, 0,  MisPc + 32'd8,  0, 1, 0, MisErr, "mis_sticky");
    step(1, 1, 0, 1, 32'h120,       0, 0,  32'h120,        1, 1, 0, MisErr, "mis_aligned_redir");
    // Reset mid-FLUSH: no residual nop, flag cleared.
    step(0, 1, 0, 0, 32'h0,         0, 0,  32'h0,          0, 0, 0, 0, "reset_in_flush");
    step(1, 1, 0, 0, 32'h0,         0, 0,  32'h4,          0, 1, 0, 0, "seq_final");

    // Let the monitor drain; anything left over is a failure.
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      bad += exp_q.size();
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
